signed_decimal_display: RTL and testbench

//  Converts a WIDTH-bit two's-complement value into a sign digit plus NDIGITS

---
 rtl/signed_decimal_display_if.sv | 36 +++
 rtl/signed_decimal_display.sv | 179 +++++++++++++++++
 tb/tb_signed_decimal_display.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/signed_decimal_display_if.sv
// ---------------------------------------------------------------------------
// signed_decimal_display_if
//   Bundles the request/result signals of signed_decimal_display.
//   master : the side that requests conversions (processor/bus side)
//   slave  : the converter itself
// Signals
//   load      request conversion of value (taken only while busy=0)
//   value     signed operand, WIDTH bits, two's complement
//   busy      conversion in progress
//   done      one-cycle pulse, new display contents valid
//   ovf       magnitude does not fit in NDIGITS decimal digits
//   sign_seg  sign digit, index 0 = segment A .. index 6 = segment G, active low
//   seg       digit k (k=0 ones) at seg[7k +: 7], same segment order
// ---------------------------------------------------------------------------
interface signed_decimal_display_if #(
    parameter int WIDTH   = 10,
    parameter int NDIGITS = 4
);
    logic                      load;
    logic signed [WIDTH-1:0]   value;
    logic                      busy;
    logic                      done;
    logic                      ovf;
    logic [0:6]                sign_seg;
    logic [0:7*NDIGITS-1]      seg;

    modport master (
        output load, value,
        input  busy, done, ovf, sign_seg, seg
    );

    modport slave (
        input  load, value,
        output busy, done, ovf, sign_seg, seg
    );
endinterface

// File: rtl/signed_decimal_display.sv
// ---------------------------------------------------------------------------
// signed_decimal_display
//   Converts a WIDTH-bit two's-complement value into a sign digit plus
//   NDIGITS decimal digits on active-low 7-segment patterns. The binary to
//   BCD conversion is sequential double-dabble: one add-3/shift step per
//   clock, WIDTH steps per conversion. Display registers keep the previous
//   result until the new one is complete, so the HEX displays never flicker.
// Parameters
//   WIDTH          input width, 2..16
//   NDIGITS        displayed decimal digits (sign excluded), 1..5
//   BLANK_LEADING  1: blank leading zeros (ones digit always shown)
// Ports
//   clk   rising-edge clock
//   rst   synchronous, active-high reset
//   bus   slave side of signed_decimal_display_if (load/value in,
//         busy/done/ovf/sign_seg/seg out)
// ---------------------------------------------------------------------------
module signed_decimal_display #(
    parameter int WIDTH         = 10,
    parameter int NDIGITS       = 4,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    signed_decimal_display_if.slave   bus
);

    // One spare BCD digit so a WIDTH=16 magnitude never corrupts the digits
    // that are shown; anything landing there is flagged as overflow anyway.
    localparam int BCD_W = 4 * (NDIGITS + 1);
    localparam int SEG_W = 7 * NDIGITS;
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [0:6] SEG_BLANK = 7'b1111111;
    localparam logic [0:6] SEG_MINUS = 7'b1111110;

    function automatic logic [31:0] pow10(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 32'd10;
        end
        return r;
    endfunction

    localparam logic [31:0] LIMIT = pow10(NDIGITS);

    function automatic logic [0:6] seg_code(input logic [3:0] d);
        logic [0:6] c;
        case (d)
            4'd0:    c = 7'b0000001;
            4'd1:    c = 7'b1001111;
            4'd2:    c = 7'b0010010;
            4'd3:    c = 7'b0000110;
            4'd4:    c = 7'b1001100;
            4'd5:    c = 7'b0100100;
            4'd6:    c = 7'b0100000;
            4'd7:    c = 7'b0001111;
            4'd8:    c = 7'b0000000;
            4'd9:    c = 7'b0001100;
            default: c = SEG_BLANK;
        endcase
        return c;
    endfunction

    // Double-dabble correction: any digit >= 5 would exceed 9 after the
    // doubling shift, so pre-add 3 to make it carry into the next digit.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < NDIGITS + 1; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Builds the digit patterns from the BCD result. Scanning from the most
    // significant digit down, zeros stay blank until the first non-zero
    // digit; the ones digit is always drawn. Overflow shows dashes.
    function automatic logic [0:SEG_W-1] display(input logic [BCD_W-1:0] b,
                                                 input logic            o);
        logic [0:SEG_W-1] s;
        logic             lead;
        logic [3:0]       d;
        s    = '1;
        lead = 1'b1;
        for (int k = NDIGITS - 1; k >= 0; k--) begin
            d = b[4*k +: 4];
            if (o) begin
                s[7*k +: 7] = SEG_MINUS;
            end else if (BLANK_LEADING && lead && (d == 4'd0) && (k > 0)) begin
                s[7*k +: 7] = SEG_BLANK;
            end else begin
                s[7*k +: 7] = seg_code(d);
                lead        = 1'b0;
            end
        end
        return s;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_UPDATE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  step;
    logic [BCD_W-1:0]  bcd;
    logic [WIDTH-1:0]  mag;
    logic              neg;
    logic              ovf_pend;

    logic [WIDTH-1:0]  mag_in;
    logic              ovf_in;
    logic [BCD_W-1:0]  bcd_adj;
    logic [BCD_W-1:0]  bcd_next;
    logic [WIDTH-1:0]  mag_next;

    always_comb begin
        // Unsigned WIDTH-bit magnitude: -2^(WIDTH-1) negates to itself,
        // which read as unsigned is exactly 2^(WIDTH-1).
        mag_in   = bus.value[WIDTH-1] ? $unsigned(-bus.value) : $unsigned(bus.value);
        ovf_in   = ({{(32-WIDTH){1'b0}}, mag_in} >= LIMIT);
        bcd_adj  = add3(bcd);
        {bcd_next, mag_next} = {bcd_adj, mag} << 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            step         <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.ovf      <= 1'b0;
            bus.sign_seg <= SEG_BLANK;
            bus.seg      <= display('0, 1'b0);
        end else begin
            bus.done <= 1'b0;
            case (state)
                // The Done cycle accepts a new load just like idle.
                S_IDLE, S_UPDATE: begin
                    if (bus.load) begin
                        neg      <= bus.value[WIDTH-1];
                        mag      <= mag_in;
                        ovf_pend <= ovf_in;
                        bcd      <= '0;
                        step     <= '0;
                        bus.busy <= 1'b1;
                        state    <= S_CONV;
                    end else begin
                        state    <= S_IDLE;
                    end
                end
                S_CONV: begin
                    bcd  <= bcd_next;
                    mag  <= mag_next;
                    step <= step + 1'b1;
                    // The last step's result goes straight to the display
                    // registers so the update lands on the same edge.
                    if (step == CNT_W'(WIDTH - 1)) begin
                        bus.seg      <= display(bcd_next, ovf_pend);
                        bus.sign_seg <= neg ? SEG_MINUS : SEG_BLANK;
                        bus.ovf      <= ovf_pend;
                        bus.busy     <= 1'b0;
                        bus.done     <= 1'b1;
                        state        <= S_UPDATE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signed_decimal_display.sv
module tb_signed_decimal_display;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    localparam logic [0:6] C0 = 7'b0000001;
    localparam logic [0:6] C1 = 7'b1001111;
    localparam logic [0:6] C2 = 7'b0010010;
    localparam logic [0:6] C3 = 7'b0000110;
    localparam logic [0:6] C4 = 7'b1001100;
    localparam logic [0:6] C5 = 7'b0100100;
    localparam logic [0:6] C7 = 7'b0001111;
    localparam logic [0:6] C9 = 7'b0001100;
    localparam logic [0:6] BL = 7'b1111111;
    localparam logic [0:6] MI = 7'b1111110;

    signed_decimal_display_if #(.WIDTH(10), .NDIGITS(4)) if0 ();
    signed_decimal_display_if #(.WIDTH(10), .NDIGITS(2)) if1 ();
    signed_decimal_display_if #(.WIDTH(10), .NDIGITS(4)) if2 ();

    signed_decimal_display #(.WIDTH(10), .NDIGITS(4), .BLANK_LEADING(1'b1)) u0 (
        .clk(clk), .rst(rst), .bus(if0.slave));
    signed_decimal_display #(.WIDTH(10), .NDIGITS(2), .BLANK_LEADING(1'b1)) u1 (
        .clk(clk), .rst(rst), .bus(if1.slave));
    signed_decimal_display #(.WIDTH(10), .NDIGITS(4), .BLANK_LEADING(1'b0)) u2 (
        .clk(clk), .rst(rst), .bus(if2.slave));

    logic [0:27] prev0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Loads all three converters at once (caller is at a negedge), waits for
    // u0's Done and checks every converter's display in that cycle.
    task automatic conv(input string tag,
                        input logic [9:0] v0, input logic [9:0] v1, input logic [9:0] v2,
                        input logic [0:27] s0, input logic [0:6] g0, input logic o0,
                        input logic [0:13] s1, input logic [0:6] g1, input logic o1,
                        input logic [0:27] s2, input logic [0:6] g2, input logic o2);
        int k;
        int got;
        if0.load = 1'b1; if0.value = v0;
        if1.load = 1'b1; if1.value = v1;
        if2.load = 1'b1; if2.value = v2;
        @(posedge clk);
        @(negedge clk);
        k = 1;
        got = 0;
        if0.load = 1'b0; if0.value = ~v0;
        if1.load = 1'b0; if1.value = ~v1;
        if2.load = 1'b0; if2.value = ~v2;
        while (got == 0 && k <= 20) begin
            if (k == 5) begin
                check({tag, " hold"}, 64'(if0.seg), 64'(prev0));
                check({tag, " busy"}, 64'(if0.busy), 64'(1'b1));
            end
            if (if0.done === 1'b1) begin
                got = k;
            end else begin
                @(negedge clk);
                k++;
            end
        end
        check({tag, " latency"}, 64'(got), 64'(11));
        check({tag, " busy0"}, 64'(if0.busy), 64'(1'b0));
        check({tag, " seg0"}, 64'(if0.seg), 64'(s0));
        check({tag, " sign0"}, 64'(if0.sign_seg), 64'(g0));
        check({tag, " ovf0"}, 64'(if0.ovf), 64'(o0));
        check({tag, " done1"}, 64'(if1.done), 64'(1'b1));
        check({tag, " seg1"}, 64'(if1.seg), 64'(s1));
        check({tag, " sign1"}, 64'(if1.sign_seg), 64'(g1));
        check({tag, " ovf1"}, 64'(if1.ovf), 64'(o1));
        check({tag, " done2"}, 64'(if2.done), 64'(1'b1));
        check({tag, " seg2"}, 64'(if2.seg), 64'(s2));
        check({tag, " sign2"}, 64'(if2.sign_seg), 64'(g2));
        check({tag, " ovf2"}, 64'(if2.ovf), 64'(o2));
        prev0 = s0;
        @(negedge clk);
        check({tag, " done drop"}, 64'(if0.done), 64'(1'b0));
    endtask

    initial begin
        int k;
        int k1;
        int k2;
        int ndone;

        rst = 1'b1;
        if0.load = 1'b0; if0.value = '0;
        if1.load = 1'b0; if1.value = '0;
        if2.load = 1'b0; if2.value = '0;

        // Reset held two cycles
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst busy", 64'(if0.busy), 64'(1'b0));
        check("rst done", 64'(if0.done), 64'(1'b0));
        check("rst ovf", 64'(if0.ovf), 64'(1'b0));
        check("rst sign", 64'(if0.sign_seg), 64'(BL));
        check("rst seg0", 64'(if0.seg), 64'({C0, BL, BL, BL}));
        check("rst seg1", 64'(if1.seg), 64'({C0, BL}));
        check("rst seg2", 64'(if2.seg), 64'({C0, C0, C0, C0}));
        prev0 = {C0, BL, BL, BL};
        rst = 1'b0;
        @(negedge clk);

        // 123 / 100 (overflow in 2 digits) / 7 without blanking
        conv("t_a", 10'd123, 10'd100, 10'd7,
             {C3, C2, C1, BL}, BL, 1'b0,
             {MI, MI}, BL, 1'b1,
             {C7, C0, C0, C0}, BL, 1'b0);
        // -512 / -99 / 0
        conv("t_b", 10'h200, 10'h39D, 10'd0,
             {C2, C1, C5, BL}, MI, 1'b0,
             {C9, C9}, MI, 1'b0,
             {C0, C0, C0, C0}, BL, 1'b0);
        // -1 / 5 / -1
        conv("t_c", 10'h3FF, 10'd5, 10'h3FF,
             {C1, BL, BL, BL}, MI, 1'b0,
             {C5, BL}, BL, 1'b0,
             {C1, C0, C0, C0}, MI, 1'b0);
        // 511 / 99 / -512
        conv("t_d", 10'd511, 10'd99, 10'h200,
             {C1, C1, C5, BL}, BL, 1'b0,
             {C9, C9}, BL, 1'b0,
             {C2, C1, C5, C0}, MI, 1'b0);
        // 105 (inner zero kept) / -100 (overflow, sign kept) / 40
        conv("t_e", 10'd105, 10'h39C, 10'd40,
             {C5, C0, C1, BL}, BL, 1'b0,
             {MI, MI}, MI, 1'b1,
             {C0, C4, C0, C0}, BL, 1'b0);

        // Load held high through a whole conversion
        if0.load = 1'b1; if0.value = 10'd200;
        @(posedge clk);
        @(negedge clk);
        k = 1;
        k1 = 0;
        if0.value = 10'd300;
        while (k1 == 0 && k <= 20) begin
            if (if0.done === 1'b1) k1 = k;
            else begin
                @(negedge clk);
                k++;
            end
        end
        check("hold first latency", 64'(k1), 64'(11));
        check("hold first seg", 64'(if0.seg), 64'({C0, C0, C2, BL}));
        @(negedge clk);
        k++;
        check("hold restart busy", 64'(if0.busy), 64'(1'b1));
        check("hold restart done", 64'(if0.done), 64'(1'b0));
        if0.load = 1'b0;
        k2 = 0;
        while (k2 == 0 && k <= 40) begin
            if (if0.done === 1'b1) k2 = k;
            else begin
                @(negedge clk);
                k++;
            end
        end
        check("hold second latency", 64'(k2), 64'(22));
        check("hold second seg", 64'(if0.seg), 64'({C0, C0, C3, BL}));
        @(negedge clk);

        // Reset during the fifth conversion cycle
        if0.load = 1'b1; if0.value = 10'd77;
        @(posedge clk);
        @(negedge clk);
        if0.load = 1'b0;
        for (int i = 1; i < 5; i++) @(negedge clk);
        check("abort busy before", 64'(if0.busy), 64'(1'b1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", 64'(if0.busy), 64'(1'b0));
        check("abort done", 64'(if0.done), 64'(1'b0));
        check("abort seg", 64'(if0.seg), 64'({C0, BL, BL, BL}));
        check("abort sign", 64'(if0.sign_seg), 64'(BL));
        check("abort seg2", 64'(if2.seg), 64'({C0, C0, C0, C0}));
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (if0.done === 1'b1) ndone++;
        end
        check("abort no done", 64'(ndone), 64'(0));
        check("abort idle", 64'(if0.busy), 64'(1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
